// File: rtl/frame_link_pkg.sv
// Shared definitions for the serial bit-stream link: FSM encoding and the
// sync pattern defaults used by both the serializer and the receiver side.
package frame_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam int         SYNC_W_DEF   = 4;
  localparam logic [3:0] SYNC_PAT_DEF = 4'b1100;

endpackage

// File: rtl/frame_serializer_piso.sv
// Parallel-load, MSB-first shift register feeding the serial line.
// Load has priority over shift; vacated LSBs fill with 0.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         serial
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= load_data;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign serial = sr[W-1];

endmodule

// File: rtl/frame_serializer.sv
// Transmit side of the serial link: accepts a word over valid/ready and sends
// sync pattern, data MSB-first and optional even parity, one bit per clock.
module frame_serializer
  import frame_link_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF),
  parameter int              PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              str_out,
  output logic              bit_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0] SYNC_TOP = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_TOP = CNT_W'(DATA_W - 1);
  // Pattern widened to the full counter range so cnt can index it directly.
  localparam logic [(2**CNT_W)-1:0] SYNC_EXT = (2**CNT_W)'(SYNC_PAT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             parity_bit;
  logic             last_bit;
  logic             accept;
  logic             shift;
  logic             serial;

  assign last_bit = (state == PARITY) ||
                    (state == DATA && cnt == '0 && PARITY_EN == 0);
  assign in_ready = (state == IDLE) || last_bit;
  assign accept   = in_valid && in_ready;
  // Advance the shifter as each data bit is copied into the str_out register.
  assign shift    = (state == SYNC && cnt == '0) || (state == DATA && cnt != '0);

  piso_shift_reg #(
    .W(DATA_W)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shift),
    .load_data(in_data),
    .serial   (serial)
  );

  // Outputs are computed for the state being entered, so they are registered
  // alongside it. An accept can only occur in IDLE or on a frame's last bit,
  // and in both cases the next cycle is the first sync bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      parity_bit  <= 1'b0;
      str_out     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (accept) begin
      state       <= SYNC;
      cnt         <= SYNC_TOP;
      parity_bit  <= ^in_data;
      str_out     <= SYNC_EXT[SYNC_TOP];
      bit_valid   <= 1'b1;
      frame_start <= 1'b1;
      busy        <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          str_out   <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end
        SYNC: begin
          if (cnt == '0) begin
            state   <= DATA;
            cnt     <= DATA_TOP;
            str_out <= serial;
          end else begin
            cnt     <= cnt - CNT_W'(1);
            str_out <= SYNC_EXT[cnt - CNT_W'(1)];
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
            str_out <= serial;
          end else if (PARITY_EN != 0) begin
            state   <= PARITY;
            str_out <= parity_bit;
          end else begin
            state     <= IDLE;
            str_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        PARITY: begin
          state     <= IDLE;
          cnt       <= '0;
          str_out   <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          str_out   <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
